// File: rtl/ahb_pkg.sv
// rtl/ahb_pkg.sv - shared AHB-Lite encodings and responder state type
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_ERR1 = 2'd2,
    ST_ERR2 = 2'd3
  } resp_state_t;

  // NONSEQ and SEQ carry a transfer; IDLE and BUSY never do.
  function automatic logic htrans_active(input logic [1:0] t);
    case (t)
      HTRANS_NONSEQ, HTRANS_SEQ: return 1'b1;
      HTRANS_IDLE, HTRANS_BUSY:  return 1'b0;
      default:                   return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ahb_lane_mask.sv
// rtl/ahb_lane_mask.sv - byte strobe and alignment check for an AHB transfer size/address
module ahb_lane_mask
  import ahb_pkg::*;
(
  input  logic [2:0] i_size,
  input  logic [1:0] i_addr,
  output logic [3:0] o_strb,
  output logic       o_align_ok
);

  // Illegal sizes report misaligned so the caller has a single legality flag.
  always_comb begin
    o_strb     = 4'b0000;
    o_align_ok = 1'b0;
    case (i_size)
      HSIZE_BYTE: begin
        o_strb     = 4'b0001 << i_addr;
        o_align_ok = 1'b1;
      end
      HSIZE_HALF: begin
        o_strb     = i_addr[1] ? 4'b1100 : 4'b0011;
        o_align_ok = ~i_addr[0];
      end
      HSIZE_WORD: begin
        o_strb     = 4'b1111;
        o_align_ok = (i_addr == 2'b00);
      end
      default: begin
        o_strb     = 4'b0000;
        o_align_ok = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/ahb_sram_responder.sv
// rtl/ahb_sram_responder.sv - AHB-Lite responder with wait states and ERROR replies fronting an inferred SRAM
module ahb_sram_responder
  import ahb_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter logic [31:0] BASE_ADDR   = 32'h0,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [2:0]  HBURST,
  input  logic [3:0]  HPROT,
  input  logic        HMASTLOCK,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic        HREADYOUT,
  output logic        HRESP,
  output logic [31:0] HRDATA
);

  localparam int          AW        = $clog2(DEPTH_WORDS);
  localparam logic [31:0] WINDOW    = 32'(DEPTH_WORDS * 4);
  localparam logic [3:0]  WAIT_INIT = 4'(WAIT_STATES);

  resp_state_t    r_state;
  resp_state_t    w_next_state;
  logic [3:0]     r_cnt;
  logic           r_write;
  logic [AW-1:0]  r_idx;
  logic [3:0]     r_strb;
  logic [31:0]    r_mem [DEPTH_WORDS];

  logic [31:0]    w_offset;
  logic           w_in_range;
  logic [3:0]     w_strb;
  logic           w_align_ok;
  logic           w_legal;
  logic           w_complete;
  logic           w_can_accept;
  logic           w_accept;
  logic           w_commit;
  logic           w_unused;

  assign w_unused = ^{HBURST, HPROT, HMASTLOCK};

  ahb_lane_mask u_lane_mask (
    .i_size     (HSIZE),
    .i_addr     (HADDR[1:0]),
    .o_strb     (w_strb),
    .o_align_ok (w_align_ok)
  );

  // Unsigned subtraction makes addresses below the base wrap high and fail the range test.
  assign w_offset     = HADDR - BASE_ADDR;
  assign w_in_range   = (w_offset < WINDOW);
  assign w_legal      = w_in_range & w_align_ok;
  assign w_complete   = (r_state == ST_DATA) && (r_cnt == 4'd0);
  assign w_can_accept = (r_state == ST_IDLE) || (r_state == ST_ERR2) || w_complete;
  assign w_accept     = w_can_accept & HSEL & htrans_active(HTRANS) & HREADY;
  assign w_commit     = w_complete & r_write;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE, ST_ERR2: begin
        if (w_accept) w_next_state = w_legal ? ST_DATA : ST_ERR1;
        else          w_next_state = ST_IDLE;
      end
      ST_DATA: begin
        if (w_complete) begin
          if (w_accept) w_next_state = w_legal ? ST_DATA : ST_ERR1;
          else          w_next_state = ST_IDLE;
        end
      end
      ST_ERR1: w_next_state = ST_ERR2;
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    HREADYOUT = 1'b1;
    HRESP     = HRESP_OKAY;
    HRDATA    = 32'h0;
    case (r_state)
      ST_DATA: begin
        HREADYOUT = (r_cnt == 4'd0);
        if (!r_write) HRDATA = r_mem[r_idx];
      end
      ST_ERR1: begin
        HREADYOUT = 1'b0;
        HRESP     = HRESP_ERROR;
      end
      ST_ERR2: HRESP = HRESP_ERROR;
      default: begin
        HREADYOUT = 1'b1;
        HRESP     = HRESP_OKAY;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt   <= 4'd0;
      r_write <= 1'b0;
      r_idx   <= '0;
      r_strb  <= 4'b0000;
    end else if (w_accept && w_legal) begin
      r_cnt   <= WAIT_INIT;
      r_write <= HWRITE;
      r_idx   <= w_offset[AW+1:2];
      r_strb  <= w_strb;
    end else if ((r_state == ST_DATA) && (r_cnt != 4'd0)) begin
      r_cnt <= r_cnt - 4'd1;
    end
  end

  // Write data is sampled on the completing edge, which is also the edge that starts a following read.
  always_ff @(posedge clk) begin
    if (w_commit) begin
      for (int i = 0; i < 4; i++) begin
        if (r_strb[i]) r_mem[r_idx][8*i +: 8] <= HWDATA[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_ahb_sram_responder.sv
// tb/tb_ahb_sram_responder.sv - self-checking bench for ahb_sram_responder against a byte-level memory model
module tb_ahb_sram_responder;
  import ahb_pkg::*;

  typedef struct {
    int          d;
    logic        sel;
    logic [31:0] addr;
    logic [1:0]  trans;
    logic        wr;
    logic [2:0]  size;
    logic [31:0] wdata;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  hsel;
  logic [31:0] haddr, hwdata;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize, hburst;
  logic [3:0]  hprot;
  logic        hmastlock;
  logic [2:0]  hreadyout, hresp;
  logic [31:0] hrdata [3];
  logic        hready;

  assign hready = &hreadyout;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    ahb_sram_responder #(
      .DEPTH_WORDS (256),
      .BASE_ADDR   ((g == 2) ? 32'h1000 : 32'h0),
      .WAIT_STATES ((g == 0) ? 0 : ((g == 1) ? 2 : 3))
    ) u_dut (
      .clk       (clk),
      .reset     (rst),
      .HSEL      (hsel[g]),
      .HADDR     (haddr),
      .HTRANS    (htrans),
      .HWRITE    (hwrite),
      .HSIZE     (hsize),
      .HBURST    (hburst),
      .HPROT     (hprot),
      .HMASTLOCK (hmastlock),
      .HWDATA    (hwdata),
      .HREADY    (hready),
      .HREADYOUT (hreadyout[g]),
      .HRESP     (hresp[g]),
      .HRDATA    (hrdata[g])
    );
  end

  int          checks = 0;
  int          failures = 0;
  logic [31:0] base_of [3] = '{32'h0, 32'h0, 32'h1000};
  int          ws_of [3] = '{0, 2, 3};
  logic [31:0] mdl [3][256];
  beat_t       bq[$];
  int          res_w [64];
  logic        res_first [64];
  logic        res_resp [64];
  logic [31:0] res_rd [64];
  int          data_cycles;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic add(input int d, input logic sel, input logic [31:0] a, input logic [1:0] t,
                     input logic w, input logic [2:0] s, input logic [31:0] wd);
    beat_t b;
    b.d = d; b.sel = sel; b.addr = a; b.trans = t; b.wr = w; b.size = s; b.wdata = wd;
    bq.push_back(b);
  endtask

  task automatic drive_addr(input int i);
    hburst    = 3'($urandom_range(0, 7));
    hprot     = 4'($urandom_range(0, 15));
    hmastlock = 1'($urandom_range(0, 1));
    if (i < bq.size()) begin
      hsel   = bq[i].sel ? 3'(1 << bq[i].d) : 3'b000;
      haddr  = bq[i].addr;
      htrans = bq[i].trans;
      hwrite = bq[i].wr;
      hsize  = bq[i].size;
    end else begin
      hsel = 3'b000; haddr = 32'h0; htrans = HTRANS_IDLE; hwrite = 1'b0; hsize = 3'b000;
    end
  endtask

  // Pipelined master: address of beat idx overlaps the data phase of beat dp.
  task automatic run_beats();
    int   idx = 0;
    int   dp = -1;
    int   cyc = 0;
    logic r;
    for (int i = 0; i < bq.size(); i++) res_w[i] = 0;
    drive_addr(0);
    while (1) begin
      @(negedge clk);
      r = hready;
      if (dp >= 0) begin
        if (!r) begin
          if (res_w[dp] == 0) res_first[dp] = hresp[bq[dp].d];
          res_w[dp]++;
        end else begin
          res_resp[dp] = hresp[bq[dp].d];
          res_rd[dp]   = hrdata[bq[dp].d];
        end
      end
      @(posedge clk);
      #1;
      if (r) begin
        if (dp == bq.size() - 1) begin
          drive_addr(bq.size());
          break;
        end
        dp = idx;
        idx++;
        hwdata = bq[dp].wdata;
        drive_addr(idx);
      end
      cyc++;
      if (cyc > 4000) begin
        checks++;
        failures++;
        $error("FAIL run_timeout got=stuck exp=complete");
        drive_addr(bq.size());
        break;
      end
    end
  endtask

  // Reference: legality from the address rules, writes applied one byte address at a time.
  function automatic void model(input beat_t b, output int ew, output logic er, output logic [31:0] ed);
    logic [31:0] off;
    logic [31:0] a;
    ew = 0; er = 1'b0; ed = 32'h0;
    if (!(b.sel && b.trans[1])) return;
    off = b.addr - base_of[b.d];
    if (!(off < 32'd1024 && b.size <= 3'd2 && (b.addr % (32'd1 << b.size)) == 0)) begin
      ew = 1; er = 1'b1;
      return;
    end
    ew = ws_of[b.d];
    if (b.wr) begin
      for (int k = 0; k < (1 << b.size); k++) begin
        a = off + 32'(k);
        mdl[b.d][a >> 2][(a % 4) * 8 +: 8] = b.wdata[(a % 4) * 8 +: 8];
      end
    end else begin
      ed = mdl[b.d][off >> 2];
    end
  endfunction

  task automatic check_run(input string step);
    int          ew;
    logic        er;
    logic [31:0] ed;
    run_beats();
    data_cycles = 0;
    for (int i = 0; i < bq.size(); i++) begin
      model(bq[i], ew, er, ed);
      chk($sformatf("%s_b%0d_waits", step, i), 32'(res_w[i]), 32'(ew));
      chk($sformatf("%s_b%0d_resp", step, i), {31'h0, res_resp[i]}, {31'h0, er});
      if (ew > 0) chk($sformatf("%s_b%0d_resp_first", step, i), {31'h0, res_first[i]}, {31'h0, er});
      chk($sformatf("%s_b%0d_rdata", step, i), res_rd[i], ed);
      data_cycles += res_w[i] + 1;
    end
    bq.delete();
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_hreadyout"}, {29'h0, hreadyout}, 32'h7);
    chk({tag, "_hresp"}, {29'h0, hresp}, 32'h0);
    for (int g = 0; g < 3; g++) chk($sformatf("%s_hrdata%0d", tag, g), hrdata[g], 32'h0);
  endtask

  initial begin
    logic [31:0] off, m, a;
    logic [2:0]  sz;
    int          d;

    rst = 1'b1;
    hsel = 3'b000; haddr = 32'h0; htrans = HTRANS_IDLE; hwrite = 1'b0; hsize = 3'b000;
    hburst = 3'b000; hprot = 4'h0; hmastlock = 1'b0; hwdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    chk_idle_outputs("reset");
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk_idle_outputs("after_reset");

    for (int g = 0; g < 3; g++) begin
      for (int blk = 0; blk < 4; blk++) begin
        for (int w = 0; w < 64; w++)
          add(g, 1'b1, base_of[g] + 32'((blk * 64 + w) * 4), (w == 0) ? HTRANS_NONSEQ : HTRANS_SEQ,
              1'b1, HSIZE_WORD, $urandom);
        check_run($sformatf("init%0d_%0d", g, blk));
      end
    end

    add(0, 1'b1, 32'h10, HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'hDEADBEEF);
    add(0, 1'b1, 32'h10, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h0);
    check_run("ws0_rw");
    chk("ws0_deadbeef", res_rd[1], 32'hDEADBEEF);
    chk("ws0_no_wait", 32'(res_w[0] + res_w[1]), 32'd0);

    add(1, 1'b1, 32'h10, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h0);
    check_run("ws2_read");
    chk("ws2_read_waits", 32'(res_w[0]), 32'd2);
    for (int i = 0; i < 4; i++)
      add(1, 1'b1, 32'h40 + 32'(4 * i), (i == 0) ? HTRANS_NONSEQ : HTRANS_SEQ, 1'b0, HSIZE_WORD, 32'h0);
    check_run("ws2_burst");
    chk("ws2_burst_cycles", 32'(data_cycles), 32'd12);

    add(0, 1'b1, 32'h20, HTRANS_NONSEQ, 1'b1, HSIZE_BYTE, {4{8'h11}});
    add(0, 1'b1, 32'h21, HTRANS_NONSEQ, 1'b1, HSIZE_BYTE, {4{8'h22}});
    add(0, 1'b1, 32'h22, HTRANS_NONSEQ, 1'b1, HSIZE_BYTE, {4{8'h33}});
    add(0, 1'b1, 32'h23, HTRANS_NONSEQ, 1'b1, HSIZE_BYTE, {4{8'h44}});
    add(0, 1'b1, 32'h20, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h0);
    add(0, 1'b1, 32'h22, HTRANS_NONSEQ, 1'b1, HSIZE_HALF, {2{16'hABCD}});
    add(0, 1'b1, 32'h20, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h0);
    check_run("lanes");
    chk("lanes_bytes", res_rd[4], 32'h44332211);
    chk("lanes_half", res_rd[6], 32'hABCD2211);

    add(1, 1'b1, 32'h02, HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'h12345678);
    add(1, 1'b1, 32'h04, HTRANS_NONSEQ, 1'b1, 3'b011, 32'h12345678);
    add(1, 1'b1, 32'h400, HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'h12345678);
    add(1, 1'b1, 32'h00, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h0);
    add(1, 1'b1, 32'h04, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h0);
    add(1, 1'b1, 32'h3FC, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h0);
    add(2, 1'b1, 32'h0FFC, HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'h0BADF00D);
    add(2, 1'b1, 32'h1400, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h0);
    add(2, 1'b1, 32'h13FF, HTRANS_NONSEQ, 1'b1, HSIZE_BYTE, 32'h5A000000);
    add(2, 1'b1, 32'h13FC, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h0);
    check_run("errors");
    chk("err_misaligned_first", {31'h0, res_first[0]}, 32'h1);
    chk("err_size_resp", {31'h0, res_resp[1]}, 32'h1);
    chk("err_range_waits", 32'(res_w[2]), 32'd1);

    add(2, 1'b1, 32'h1030, HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'hCAFEF00D);
    add(2, 1'b1, 32'h1030, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h0);
    add(2, 1'b1, 32'h1030, HTRANS_IDLE, 1'b1, HSIZE_WORD, 32'h0);
    add(2, 1'b1, 32'h1030, HTRANS_BUSY, 1'b1, HSIZE_WORD, 32'h0);
    add(2, 1'b1, 32'h1030, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h0);
    add(0, 1'b1, 32'h30, HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'hCAFEF00D);
    add(0, 1'b1, 32'h30, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h0);
    check_run("b2b");
    chk("b2b_ws3_raw", res_rd[1], 32'hCAFEF00D);
    chk("b2b_idle_busy_nowrite", res_rd[4], 32'hCAFEF00D);
    chk("b2b_ws0_raw", res_rd[6], 32'hCAFEF00D);

    hsel = 3'b100; haddr = 32'h1040; htrans = HTRANS_NONSEQ; hwrite = 1'b1; hsize = HSIZE_WORD;
    @(posedge clk);
    #1;
    hsel = 3'b000; htrans = HTRANS_IDLE; hwrite = 1'b0; hwdata = 32'h5555AAAA;
    chk("rst_mid_wait1", {31'h0, hreadyout[2]}, 32'h0);
    @(posedge clk);
    #1;
    chk("rst_mid_wait2", {31'h0, hreadyout[2]}, 32'h0);
    rst = 1'b1;
    #1;
    chk_idle_outputs("rst_mid");
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    add(2, 1'b1, 32'h1040, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h0);
    check_run("rst_mid_read");

    for (int round = 0; round < 4; round++) begin
      for (int k = 0; k < 40; k++) begin
        d = int'($urandom_range(0, 2));
        case ($urandom_range(0, 5))
          0:       off = $urandom_range(0, 1023);
          1:       off = 32'd1020 + $urandom_range(0, 7);
          2:       off = 32'hFFFFFFFC + $urandom_range(0, 3);
          default: off = $urandom_range(0, 63);
        endcase
        sz = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 2)) : 3'($urandom_range(3, 7));
        m = (32'd1 << sz) - 32'd1;
        if (sz <= 3'd2 && $urandom_range(0, 3) != 0) off = off & ~m;
        a = base_of[d] + off;
        add(d, ($urandom_range(0, 9) != 0), a,
            ($urandom_range(0, 4) != 0) ? 2'($urandom_range(2, 3)) : 2'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), sz, $urandom);
      end
      check_run($sformatf("rand%0d", round));
    end

    #1;
    chk_idle_outputs("final");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
